// File: rtl/pc_sequencer_if.sv
// Handshake and control bundle between the PC sequencer and the
// memories/decoder/datapath it steers.
interface pc_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             halt;
    logic             imem_req;
    logic             imem_ready;
    logic             ir_we;
    logic             is_branch;
    logic             is_load;
    logic             is_store;
    logic             is_halt;
    logic             branch_taken;
    logic             dmem_req;
    logic             dmem_ready;
    logic             reg_we;
    logic             pc_en;
    logic             npc_sel;
    logic             fault;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired_count;

    modport master (
        input  start, halt, imem_ready, is_branch, is_load,
        input  is_store, is_halt, branch_taken, dmem_ready,
        output imem_req, ir_we, dmem_req, reg_we, pc_en,
        output npc_sel, fault, state, retired_count
    );

    modport slave (
        output start, halt, imem_ready, is_branch, is_load,
        output is_store, is_halt, branch_taken, dmem_ready,
        input  imem_req, ir_we, dmem_req, reg_we, pc_en,
        input  npc_sel, fault, state, retired_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer driving the PC update
// strobe and next-PC select, with retire counting and memory timeouts.
module pc_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input logic            clk,
    input logic            reset,
    pc_sequencer_if.master bus
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t            state_q;
    logic [WAIT_W-1:0] wait_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              fault_q;
    logic              load_q;

    logic imem_req;
    logic ir_we;
    logic dmem_req;
    logic reg_we;
    logic retire;
    logic npc_sel;

    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        reg_we   = 1'b0;
        retire   = 1'b0;
        npc_sel  = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_we    = bus.imem_ready;
            end
            S_EXEC: begin
                if (bus.is_branch) begin
                    retire  = 1'b1;
                    npc_sel = bus.branch_taken;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                retire   = bus.dmem_ready && !load_q;
            end
            S_WB: begin
                reg_we = 1'b1;
                retire = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q <= S_FETCH;
                        wait_q  <= '0;
                    end
                end
                S_FETCH: begin
                    if (bus.imem_ready) begin
                        state_q <= S_DECODE;
                    end else if (wait_q == WAIT_LAST) begin
                        fault_q <= 1'b1;
                        state_q <= S_HALT;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                S_DECODE: state_q <= bus.is_halt ? S_HALT : S_EXEC;
                S_EXEC: begin
                    // class flags are only valid here, so keep load vs store
                    load_q <= bus.is_load;
                    if (bus.is_load || bus.is_store) begin
                        state_q <= S_MEM;
                        wait_q  <= '0;
                    end else if (!bus.is_branch) begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (bus.dmem_ready) begin
                        if (load_q) state_q <= S_WB;
                    end else if (wait_q == WAIT_LAST) begin
                        fault_q <= 1'b1;
                        state_q <= S_HALT;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                S_WB:   ;
                S_HALT: ;
                default: state_q <= S_IDLE;
            endcase
            if (retire) begin
                cnt_q   <= cnt_q + CNT_W'(1);
                wait_q  <= '0;
                state_q <= bus.halt ? S_HALT : S_FETCH;
            end
        end
    end

    assign bus.imem_req      = imem_req;
    assign bus.ir_we         = ir_we;
    assign bus.dmem_req      = dmem_req;
    assign bus.reg_we        = reg_we;
    assign bus.pc_en         = retire;
    assign bus.npc_sel       = npc_sel;
    assign bus.fault         = fault_q;
    assign bus.state         = state_q;
    assign bus.retired_count = cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table, hand-written
// corner sequences and randomized instructions against a latency model.
module tb_pc_sequencer;
    localparam int ALU = 0;
    localparam int BR  = 1;
    localparam int LD  = 2;
    localparam int ST  = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pc_sequencer_if #(.CNT_W(32)) bus ();
    pc_sequencer_if #(.CNT_W(2))  bus2 ();

    pc_sequencer #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    pc_sequencer #(.MEM_TIMEOUT(15), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int cls; bit tk; int iw; int dw; bit hl;
        int lat; bit npc; int rwe; int dreq;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input longint act,
                         input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic set_cls(input int cls);
        bus.is_branch = (cls == BR);
        bus.is_load   = (cls == LD);
        bus.is_store  = (cls == ST);
        bus.is_halt   = (cls == 4);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.start = 1'b0;
        bus.halt = 1'b0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.branch_taken = 1'b0;
        set_cls(ALU);
        #2;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic go();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("start_fetch", bus.state, 1);
    endtask

    // Runs one instruction starting in FETCH, ends at the negedge after retire.
    task automatic run_instr(input string tag, input int cls, input bit tk,
                             input int iw, input int dw, input bit hl,
                             input int e_lat, input bit e_npc,
                             input int e_rwe, input int e_dreq);
        int lat = 0, rwe = 0, dreq = 0, irw = 0, pcs = 0;
        int fc = 0, dc = 0, bad = 0;
        bit npc = 1'b0;
        set_cls(cls);
        bus.branch_taken = tk;
        bus.halt = hl;
        while (pcs == 0 && lat < 64) begin
            bus.imem_ready = (fc == iw);
            bus.dmem_ready = (dc == dw);
            #1;
            lat++;
            if (bus.imem_req) fc++;
            if (bus.dmem_req) begin dc++; dreq++; end
            if (bus.reg_we) rwe++;
            if (bus.ir_we) irw++;
            if (bus.ir_we && (bus.reg_we || bus.pc_en)) bad++;
            if (bus.pc_en) begin pcs++; npc = bus.npc_sel; end
            @(negedge clk);
        end
        bus.halt = 1'b0;
        check({tag, "_pc_en"}, pcs, 1);
        check({tag, "_lat"}, lat, e_lat);
        check({tag, "_npc"}, npc, e_npc);
        check({tag, "_reg_we"}, rwe, e_rwe);
        check({tag, "_dmem_req"}, dreq, e_dreq);
        check({tag, "_ir_we"}, irw, 1);
        check({tag, "_excl"}, bad, 0);
    endtask

    // Reference: each stage costs one cycle plus its wait cycles.
    function automatic int m_lat(input int cls, input int iw, input int dw);
        int n;
        n = (1 + iw) + 1 + 1;
        if (cls == LD || cls == ST) n += 1 + dw;
        if (cls == ALU || cls == LD) n += 1;
        return n;
    endfunction

    initial begin
        bus.start = 1'b0; bus.halt = 1'b0;
        bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
        bus.branch_taken = 1'b0;
        set_cls(ALU);
        bus2.start = 1'b0; bus2.halt = 1'b0;
        bus2.imem_ready = 1'b1; bus2.dmem_ready = 1'b1;
        bus2.is_branch = 1'b0; bus2.is_load = 1'b0;
        bus2.is_store = 1'b0; bus2.is_halt = 1'b0;
        bus2.branch_taken = 1'b0;

        tbl[0] = '{ALU, 0, 0,  0, 0, 4,  0, 1, 0};
        tbl[1] = '{BR,  1, 0,  0, 0, 3,  1, 0, 0};
        tbl[2] = '{BR,  0, 0,  0, 0, 3,  0, 0, 0};
        tbl[3] = '{LD,  0, 0,  3, 0, 8,  0, 1, 4};
        tbl[4] = '{ALU, 0, 14, 0, 0, 18, 0, 1, 0};
        tbl[5] = '{ST,  0, 1,  2, 0, 7,  0, 0, 3};
        tbl[6] = '{LD,  0, 2,  0, 0, 7,  0, 1, 1};
        tbl[7] = '{ST,  0, 0,  0, 1, 4,  0, 0, 1};

        #2;
        reset = 1'b0;
        @(negedge clk);
        check("rst_state", bus.state, 0);
        check("rst_strobes", {bus.imem_req, bus.ir_we, bus.dmem_req,
                              bus.reg_we, bus.pc_en}, 0);
        check("rst_fault", bus.fault, 0);
        check("rst_count", bus.retired_count, 0);

        go();
        for (int i = 0; i < 8; i++)
            run_instr($sformatf("vec%0d", i), tbl[i].cls, tbl[i].tk,
                      tbl[i].iw, tbl[i].dw, tbl[i].hl, tbl[i].lat,
                      tbl[i].npc, tbl[i].rwe, tbl[i].dreq);
        check("vec_count", bus.retired_count, 8);
        check("vec_halt_state", bus.state, 6);
        check("vec_fault", bus.fault, 0);
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("halt_ignores_start", {bus.state, bus.pc_en}, 6 << 1);
        end
        bus.start = 1'b0;

        // fetch timeout
        do_reset();
        go();
        repeat (14) @(negedge clk);
        check("to_pre_fault", bus.fault, 0);
        check("to_pre_state", bus.state, 1);
        check("to_pre_req", bus.imem_req, 1);
        @(negedge clk);
        check("to_fault", bus.fault, 1);
        check("to_state", bus.state, 6);
        check("to_req_low", bus.imem_req, 0);

        // decode of a halt instruction
        do_reset();
        go();
        set_cls(4);
        bus.imem_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("is_halt_state", bus.state, 6);
        check("is_halt_count", bus.retired_count, 0);

        // reset while waiting in MEM
        do_reset();
        go();
        run_instr("pre", ALU, 0, 0, 0, 0, 4, 0, 1, 0);
        check("pre_count", bus.retired_count, 1);
        set_cls(LD);
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_state", bus.state, 4);
        check("mid_dreq", bus.dmem_req, 1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_state", bus.state, 0);
        check("ar_strobes", {bus.dmem_req, bus.pc_en, bus.reg_we}, 0);
        check("ar_count", bus.retired_count, 0);
        @(negedge clk);
        reset = 1'b0;
        check("ar_hold_state", bus.state, 0);

        // randomized program against the latency model
        do_reset();
        go();
        for (int i = 0; i < 50; i++) begin
            int c, iw, dw;
            bit tk, hl;
            c  = int'($urandom_range(3, 0));
            tk = 1'($urandom_range(1, 0));
            iw = int'($urandom_range(3, 0));
            dw = int'($urandom_range(3, 0));
            hl = (i == 49);
            run_instr($sformatf("rnd%0d", i), c, tk, iw, dw, hl,
                      m_lat(c, iw, dw), (c == BR) && tk,
                      (c == ALU || c == LD) ? 1 : 0,
                      (c == LD || c == ST) ? dw + 1 : 0);
        end
        check("rnd_count", bus.retired_count, 50);
        check("rnd_state", bus.state, 6);
        check("rnd_fault", bus.fault, 0);

        // counter wrap on the narrow instance
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        repeat (12) @(negedge clk);
        check("wrap_pre", bus2.retired_count, 3);
        repeat (4) @(negedge clk);
        check("wrap", bus2.retired_count, 0);
        check("wrap_state", bus2.state, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
